ma_multi_controller: RTL
========================

Name: ma_multi_controller

Overview:
- Next-generation memory-access controller between the instruction front end and the DDR4 datamovers.
- Accepts one load/store command per valid/ready handshake. Reads the base address from the ARF with a configurable read latency and adds the offset.
- Issues a one-cycle start to a parametrised number of MRF datamover channels, or to the VRF load or VRF store datamover.
- Collects sticky per-channel done. Reports completion with a done pulse; a watchdog timeout reports completion with an error pulse.

Parameters:
NUM_OF_DDR4, 4, number of DDR4 calibration inputs
DDR4_ADDRWIDTH, 36, AXI byte-address width
ARF_ADDRWIDTH, 5, ARF index width
VRF_ADDRWIDTH, 10, VRF row address width
MRF_ADDRWIDTH, 6, MRF row address width
NUM_MRF_CH, 4, MRF datamover channels (1..8)
MRF_CHUNK_BYTES, 2048, bytes per MRF channel transfer; also the channel address stride
VRF_BYTES, 128, bytes per VRF transfer
BTT_WIDTH, 15, byte_to_trans width
ARF_RD_LAT, 2, cycles from arf_en_o to valid arf_dout_i (1..4)
TIMEOUT_CYCLES, 65535, WAIT_DONE watchdog limit; 0 disables the watchdog

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
ma_ddr4_calib_complete_i  in  NUM_OF_DDR4  per-DDR4 calibration done
ma_ddr4_linkup_o  out  1  all DDR4 calibrated (sticky)
ma_cmd_valid_i  in  1  command valid
ma_cmd_ready_o  out  1  controller can accept a command
ma_select_v_m_i  in  1  1 = MRF, 0 = VRF
ma_v_load_or_store_i  in  1  VRF only: 0 = load, 1 = store
ma_v_m_reg_i  in  VRF_ADDRWIDTH  VRF/MRF row (MRF uses the low MRF_ADDRWIDTH bits)
ma_a_reg_i  in  ARF_ADDRWIDTH  ARF index
ma_a_offset_i  in  DDR4_ADDRWIDTH  byte offset
ma_done_o  out  1  one-cycle completion pulse
ma_err_o  out  1  one-cycle timeout pulse, coincident with ma_done_o
arf_en_o  out  1  ARF read enable
arf_we_o  out  1  tied 0
arf_addr_o  out  ARF_ADDRWIDTH  ARF read index
arf_dout_i  in  DDR4_ADDRWIDTH  ARF read data
mrf_start_o  out  NUM_MRF_CH  per-channel start pulse
mrf_src_axi_addr_o  out  NUM_MRF_CH*DDR4_ADDRWIDTH  channel k source address in slice k
mrf_dst_bram_addr_o  out  MRF_ADDRWIDTH  common MRF row
mrf_done_i  in  NUM_MRF_CH  per-channel done pulse
vrf_ldr_start_o  out  1  VRF load start
vrf_ldr_src_axi_addr_o  out  DDR4_ADDRWIDTH  VRF load source address
vrf_ldr_dst_bram_addr_o  out  VRF_ADDRWIDTH  VRF load destination row
vrf_ldr_done_i  in  1  VRF load done
vrf_str_start_o  out  1  VRF store start
vrf_str_dst_axi_addr_o  out  DDR4_ADDRWIDTH  VRF store destination address
vrf_str_src_bram_addr_o  out  VRF_ADDRWIDTH  VRF store source row
vrf_str_done_i  in  1  VRF store done
byte_to_trans_o  out  BTT_WIDTH  transfer length, shared by all datamovers

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: all outputs 0, state WAIT_CALIB, command latch and sticky-done register cleared. Reset mid-transfer aborts the command with no done pulse.
- Linkup:
  - In WAIT_CALIB, go to IDLE and set ma_ddr4_linkup_o when &ma_ddr4_calib_complete_i.
  - Linkup stays 1 until reset; later calibration drops are ignored.
- IDLE:
  - ma_cmd_ready_o = 1 (registered, high only in IDLE).
  - On valid&ready, latch every command field, drive arf_en_o = 1 and arf_addr_o = ma_a_reg_i, go to ARF_RD.
- ARF_RD:
  - Hold arf_en_o for one cycle, then drop it.
  - Count ARF_RD_LAT cycles from the enable, then capture arf_dout_i and go to CALC.
- CALC: eff = base + offset, modulo 2^DDR4_ADDRWIDTH, registered.
- START: single cycle. Clears sticky done, then drives the selected start output(s) for exactly this cycle.
  - MRF: all NUM_MRF_CH bits of mrf_start_o; slice k = eff + k*MRF_CHUNK_BYTES (truncated); byte_to_trans_o = MRF_CHUNK_BYTES; mrf_dst_bram_addr_o = row[MRF_ADDRWIDTH-1:0].
  - VRF load/store: only the selected start; addresses from eff/row; byte_to_trans_o = VRF_BYTES.
  - Address and length outputs hold their values until the next START.
- WAIT_DONE:
  - Sticky-OR the done inputs of the active path.
  - Complete when all NUM_MRF_CH bits are collected (MRF), or the selected VRF done is seen (VRF).
  - Dones may arrive in any order and on the same cycle; dones for inactive paths are ignored.
  - Watchdog counter increments each cycle. On reaching TIMEOUT_CYCLES (when non-zero), complete with error.
  - Completion goes to RESP.
- RESP: ma_done_o = 1 for one cycle; ma_err_o = 1 in the same cycle if timed out. Then IDLE.
- Latency: ARF_RD_LAT + 4 cycles from handshake to start pulse. Done pulse 2 cycles after the completing done input.
- Commands offered outside IDLE are not accepted (ready = 0); the command must be held by the sender.

Test Plan:
- Calib 4'b0111 for 10 cycles, then 4'b1111 -> linkup rises the next cycle; ready the cycle after; dropping calib later leaves linkup = 1.
- MRF command with ARF[3] = 0x1_0000_0000 and offset 0x100 -> start 4'b1111, slices 0x1_0000_0100/0900/1100/1900, byte_to_trans 2048; mrf_done pulses 0,2,1,3 on separate cycles -> single ma_done_o 2 cycles after channel 3's done, err 0.
- VRF load with row 0x3A5, base 0x40, offset 0x80 -> only vrf_ldr_start_o pulses, src 0xC0, dst 0x3A5, byte_to_trans 128; a vrf_str_done_i pulse is ignored; vrf_ldr_done_i -> done.
- Address wrap: base 0xF_FFFF_FFC0, offset 0x80 -> eff 0x40; slice 3 = 0x1840.
- Timeout with TIMEOUT_CYCLES = 16 and mrf_done_i = 4'b0111 only -> ma_done_o and ma_err_o pulse together after 16 WAIT_DONE cycles; the next command runs normally.
- Reset asserted during WAIT_DONE -> all outputs 0 asynchronously; after release the controller waits for calibration again with no stale done pulse.

Source files
------------

// File: rtl/ma_multi_controller.sv
// Memory-access controller: reads the ARF base, adds the offset, starts the MRF or VRF
// datamovers and reports completion (or a watchdog timeout) back to the front end.
module ma_multi_controller #(
    parameter int NUM_OF_DDR4     = 4,
    parameter int DDR4_ADDRWIDTH  = 36,
    parameter int ARF_ADDRWIDTH   = 5,
    parameter int VRF_ADDRWIDTH   = 10,
    parameter int MRF_ADDRWIDTH   = 6,
    parameter int NUM_MRF_CH      = 4,
    parameter int MRF_CHUNK_BYTES = 2048,
    parameter int VRF_BYTES       = 128,
    parameter int BTT_WIDTH       = 15,
    parameter int ARF_RD_LAT      = 2,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_OF_DDR4-1:0]               ma_ddr4_calib_complete_i,
    output logic                                 ma_ddr4_linkup_o,
    input  logic                                 ma_cmd_valid_i,
    output logic                                 ma_cmd_ready_o,
    input  logic                                 ma_select_v_m_i,
    input  logic                                 ma_v_load_or_store_i,
    input  logic [VRF_ADDRWIDTH-1:0]             ma_v_m_reg_i,
    input  logic [ARF_ADDRWIDTH-1:0]             ma_a_reg_i,
    input  logic [DDR4_ADDRWIDTH-1:0]            ma_a_offset_i,
    output logic                                 ma_done_o,
    output logic                                 ma_err_o,
    output logic                                 arf_en_o,
    output logic                                 arf_we_o,
    output logic [ARF_ADDRWIDTH-1:0]             arf_addr_o,
    input  logic [DDR4_ADDRWIDTH-1:0]            arf_dout_i,
    output logic [NUM_MRF_CH-1:0]                mrf_start_o,
    output logic [NUM_MRF_CH*DDR4_ADDRWIDTH-1:0] mrf_src_axi_addr_o,
    output logic [MRF_ADDRWIDTH-1:0]             mrf_dst_bram_addr_o,
    input  logic [NUM_MRF_CH-1:0]                mrf_done_i,
    output logic                                 vrf_ldr_start_o,
    output logic [DDR4_ADDRWIDTH-1:0]            vrf_ldr_src_axi_addr_o,
    output logic [VRF_ADDRWIDTH-1:0]             vrf_ldr_dst_bram_addr_o,
    input  logic                                 vrf_ldr_done_i,
    output logic                                 vrf_str_start_o,
    output logic [DDR4_ADDRWIDTH-1:0]            vrf_str_dst_axi_addr_o,
    output logic [VRF_ADDRWIDTH-1:0]             vrf_str_src_bram_addr_o,
    input  logic                                 vrf_str_done_i,
    output logic [BTT_WIDTH-1:0]                 byte_to_trans_o
);

    // state      | meaning
    // WAIT_CALIB | waiting for every DDR4 to report calibration
    // IDLE       | ready for a command
    // ARF_RD     | ARF read in flight, base captured after ARF_RD_LAT cycles
    // CALC       | effective address = base + offset
    // START      | clear sticky done, launch datamover(s)
    // WAIT_DONE  | collect done inputs, watchdog running
    // RESP       | report completion (and timeout)
    typedef enum logic [2:0] {
        S_WAIT_CALIB, S_IDLE, S_ARF_RD, S_CALC, S_START, S_WAIT_DONE, S_RESP
    } state_t;

    localparam logic [2:0]  ARF_LAST = 3'(ARF_RD_LAT);
    localparam logic [31:0] WD_LAST  = 32'(TIMEOUT_CYCLES - 1);

    state_t state_q, state_d;

    logic                          sel_m_q, ls_q, to_q, vrf_sticky_q;
    logic [VRF_ADDRWIDTH-1:0]      row_q;
    logic [DDR4_ADDRWIDTH-1:0]     off_q, base_q, eff_q;
    logic [2:0]                    arf_cnt_q;
    logic [31:0]                   wd_cnt_q;
    logic [NUM_MRF_CH-1:0]         mrf_sticky_q;
    logic [NUM_MRF_CH*DDR4_ADDRWIDTH-1:0] mrf_addr_d;

    logic hs, vrf_done_sel, complete, timeout;

    assign arf_we_o     = 1'b0;
    assign hs           = ma_cmd_valid_i & ma_cmd_ready_o;
    assign vrf_done_sel = ls_q ? vrf_str_done_i : vrf_ldr_done_i;
    assign complete     = sel_m_q ? (&(mrf_sticky_q | mrf_done_i)) : (vrf_sticky_q | vrf_done_sel);
    assign timeout      = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == WD_LAST);

    always_comb begin
        mrf_addr_d = '0;
        for (int k = 0; k < NUM_MRF_CH; k++) begin
            mrf_addr_d[k*DDR4_ADDRWIDTH +: DDR4_ADDRWIDTH] =
                eff_q + DDR4_ADDRWIDTH'(k * MRF_CHUNK_BYTES);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_CALIB: if (&ma_ddr4_calib_complete_i) state_d = S_IDLE;
            S_IDLE:       if (hs) state_d = S_ARF_RD;
            S_ARF_RD:     if (arf_cnt_q == ARF_LAST) state_d = S_CALC;
            S_CALC:       state_d = S_START;
            S_START:      state_d = S_WAIT_DONE;
            S_WAIT_DONE:  if (complete || timeout) state_d = S_RESP;
            S_RESP:       state_d = S_IDLE;
            default:      state_d = S_WAIT_CALIB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q                 <= S_WAIT_CALIB;
            sel_m_q                 <= 1'b0;
            ls_q                    <= 1'b0;
            to_q                    <= 1'b0;
            vrf_sticky_q            <= 1'b0;
            row_q                   <= '0;
            off_q                   <= '0;
            base_q                  <= '0;
            eff_q                   <= '0;
            arf_cnt_q               <= '0;
            wd_cnt_q                <= '0;
            mrf_sticky_q            <= '0;
            ma_ddr4_linkup_o        <= 1'b0;
            ma_cmd_ready_o          <= 1'b0;
            ma_done_o               <= 1'b0;
            ma_err_o                <= 1'b0;
            arf_en_o                <= 1'b0;
            arf_addr_o              <= '0;
            mrf_start_o             <= '0;
            mrf_src_axi_addr_o      <= '0;
            mrf_dst_bram_addr_o     <= '0;
            vrf_ldr_start_o         <= 1'b0;
            vrf_ldr_src_axi_addr_o  <= '0;
            vrf_ldr_dst_bram_addr_o <= '0;
            vrf_str_start_o         <= 1'b0;
            vrf_str_dst_axi_addr_o  <= '0;
            vrf_str_src_bram_addr_o <= '0;
            byte_to_trans_o         <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_WAIT_CALIB && state_d == S_IDLE) ma_ddr4_linkup_o <= 1'b1;
            // ready drops in the same edge that accepts a command
            ma_cmd_ready_o <= (state_q == S_IDLE) && (state_d == S_IDLE);
            arf_en_o       <= (state_q == S_IDLE) && hs;
            if (state_q == S_IDLE && hs) begin
                sel_m_q    <= ma_select_v_m_i;
                ls_q       <= ma_v_load_or_store_i;
                row_q      <= ma_v_m_reg_i;
                off_q      <= ma_a_offset_i;
                arf_addr_o <= ma_a_reg_i;
                arf_cnt_q  <= '0;
            end
            if (state_q == S_ARF_RD) begin
                arf_cnt_q <= arf_cnt_q + 3'd1;
                if (arf_cnt_q == ARF_LAST) base_q <= arf_dout_i;
            end
            if (state_q == S_CALC) eff_q <= base_q + off_q;

            mrf_start_o     <= (state_q == S_START && sel_m_q) ? '1 : '0;
            vrf_ldr_start_o <= (state_q == S_START) && !sel_m_q && !ls_q;
            vrf_str_start_o <= (state_q == S_START) && !sel_m_q && ls_q;
            if (state_q == S_START) begin
                mrf_sticky_q <= '0;
                vrf_sticky_q <= 1'b0;
                wd_cnt_q     <= '0;
                to_q         <= 1'b0;
                if (sel_m_q) begin
                    mrf_src_axi_addr_o  <= mrf_addr_d;
                    mrf_dst_bram_addr_o <= row_q[MRF_ADDRWIDTH-1:0];
                    byte_to_trans_o     <= BTT_WIDTH'(MRF_CHUNK_BYTES);
                end else begin
                    byte_to_trans_o <= BTT_WIDTH'(VRF_BYTES);
                    if (ls_q) begin
                        vrf_str_dst_axi_addr_o  <= eff_q;
                        vrf_str_src_bram_addr_o <= row_q;
                    end else begin
                        vrf_ldr_src_axi_addr_o  <= eff_q;
                        vrf_ldr_dst_bram_addr_o <= row_q;
                    end
                end
            end
            if (state_q == S_WAIT_DONE) begin
                mrf_sticky_q <= mrf_sticky_q | (sel_m_q ? mrf_done_i : '0);
                vrf_sticky_q <= vrf_sticky_q | (!sel_m_q && vrf_done_sel);
                wd_cnt_q     <= wd_cnt_q + 32'd1;
                // a real completion on the last watchdog cycle wins over the timeout
                to_q         <= timeout && !complete;
            end
            ma_done_o <= (state_q == S_RESP);
            ma_err_o  <= (state_q == S_RESP) && to_q;
        end
    end

endmodule
